i2c_xfer_sched: RTL and testbench

- Transaction scheduler that shares one byte-level I2C master engine between NUM_REQ requesters.
- Each requester posts an EEPROM-style descriptor: 7-bit device, R/W, 8-bit memory address, length 1..MAX_LEN.
- The block arbitrates round-robin between requesters and expands the granted descriptor into the engine command sequence START/WRITE/READ/STOP.
- It streams data to and from the owner and reports completion or error. It sits between the peripheral bus agents and the I2C master PHY engine.

---
 rtl/i2c_sched_pkg.sv | 41 ++++
 rtl/i2c_rr_arbiter.sv | 31 +++
 rtl/i2c_xfer_sched.sv | 173 +++++++++++++++++
 tb/tb_i2c_xfer_sched.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_sched_pkg.sv
// Shared types and helpers for the I2C transaction scheduler (i2c_xfer_sched).
package i2c_sched_pkg;

  typedef enum logic [1:0] {
    OP_START = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2,
    OP_STOP  = 2'd3
  } cmd_op_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_GRANT,
    S_START,
    S_DEV_W,
    S_MADDR,
    S_WDATA,
    S_RSTART,
    S_DEV_R,
    S_RDATA,
    S_STOP,
    S_DONE
  } sched_state_e;

  typedef logic [6:0] i2c_addr_t;
  typedef logic [7:0] i2c_byte_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // States that own an outstanding engine command.
  function automatic logic is_cmd_state(sched_state_e s);
    return s inside {S_START, S_DEV_W, S_MADDR, S_WDATA, S_RSTART, S_DEV_R, S_RDATA, S_STOP};
  endfunction

  // States whose command is a WRITE, i.e. may be NACKed by the slave.
  function automatic logic is_write_state(sched_state_e s);
    return s inside {S_DEV_W, S_MADDR, S_WDATA, S_DEV_R};
  endfunction

endpackage

// File: rtl/i2c_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module i2c_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   idx,
  output logic               any_valid
);

  int unsigned cand;

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    winner    = '0;
    idx       = '0;
    any_valid = 1'b0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!any_valid && req[cand]) begin
        any_valid    = 1'b1;
        idx          = IDX_W'(cand);
        winner[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_xfer_sched.sv
// Shares one byte-level I2C master engine between NUM_REQ EEPROM-style requesters.
// Optional response watchdog enabled by defining I2C_XFER_SCHED_TIMEOUT_EN.
module i2c_xfer_sched
  import i2c_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int LEN_W          = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*7-1:0]     req_dev_i,
  input  logic [NUM_REQ-1:0]       req_rd_i,
  input  logic [NUM_REQ*8-1:0]     req_addr_i,
  input  logic [NUM_REQ*LEN_W-1:0] req_len_i,
  input  logic [NUM_REQ*8-1:0]     wdata_i,
  output logic [NUM_REQ-1:0]       wtake_o,
  output logic [7:0]               rdata_o,
  output logic [NUM_REQ-1:0]       rvalid_o,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [NUM_REQ-1:0]       done_o,
  output logic                     err_o,
  output logic                     cmd_valid_o,
  input  logic                     cmd_ready_i,
  output logic [1:0]               cmd_op_o,
  output logic [7:0]               cmd_data_o,
  output logic                     cmd_nack_o,
  input  logic                     rsp_valid_i,
  input  logic [7:0]               rsp_data_i,
  input  logic                     rsp_nack_i,
  output logic                     eng_abort_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [LEN_W:0] REM_ONE = (LEN_W + 1)'(1);

  sched_state_e         state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, owner_q;
  logic [NUM_REQ-1:0]   gnt_q, rvalid_q;
  i2c_addr_t            dev_q;
  logic                 rd_q, err_q, wait_q;
  i2c_byte_t            addr_q, rdata_q;
  logic [LEN_W:0]       rem_q;

  logic [NUM_REQ-1:0]   win;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_any;

  logic                 in_cmd, fire, cmd_done, last_byte, timeout;
  cmd_op_e              cmd_op;
  i2c_byte_t            cmd_data;

  i2c_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req       (req_i),
    .ptr       (ptr_q),
    .winner    (win),
    .idx       (win_idx),
    .any_valid (win_any)
  );

  // A command is offered until accepted, then the state waits for its single response.
  assign in_cmd    = is_cmd_state(state_q);
  assign fire      = in_cmd && !wait_q && cmd_ready_i;
  assign cmd_done  = (wait_q || fire) && rsp_valid_i;
  assign last_byte = (rem_q == REM_ONE);

`ifdef I2C_XFER_SCHED_TIMEOUT_EN
  logic [15:0] to_cnt_q;

  assign timeout     = in_cmd && !cmd_done && (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));
  assign eng_abort_o = timeout;

  always_ff @(posedge clk_i) begin
    if (rst_i || !in_cmd || cmd_done) to_cnt_q <= '0;
    else                              to_cnt_q <= to_cnt_q + 16'd1;
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout     = 1'b0;
  assign eng_abort_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (win_any) state_d = S_GRANT;
      S_GRANT:  state_d = S_START;
      S_START:  if (cmd_done) state_d = S_DEV_W;
      S_DEV_W:  if (cmd_done) state_d = rsp_nack_i ? S_STOP : S_MADDR;
      S_MADDR:  if (cmd_done) state_d = rsp_nack_i ? S_STOP : (rd_q ? S_RSTART : S_WDATA);
      S_WDATA:  if (cmd_done && (rsp_nack_i || last_byte)) state_d = S_STOP;
      S_RSTART: if (cmd_done) state_d = S_DEV_R;
      S_DEV_R:  if (cmd_done) state_d = rsp_nack_i ? S_STOP : S_RDATA;
      S_RDATA:  if (cmd_done && last_byte) state_d = S_STOP;
      S_STOP:   if (cmd_done) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (timeout) state_d = S_DONE;
  end

  always_comb begin
    cmd_op   = OP_START;
    cmd_data = '0;
    case (state_q)
      S_DEV_W: begin cmd_op = OP_WRITE; cmd_data = {dev_q, RW_WRITE}; end
      S_MADDR: begin cmd_op = OP_WRITE; cmd_data = addr_q; end
      S_WDATA: begin cmd_op = OP_WRITE; cmd_data = wdata_i[int'(owner_q)*8 +: 8]; end
      S_DEV_R: begin cmd_op = OP_WRITE; cmd_data = {dev_q, RW_READ}; end
      S_RDATA: cmd_op = OP_READ;
      S_STOP:  cmd_op = OP_STOP;
      default: ;
    endcase
  end

  assign cmd_valid_o = in_cmd && !wait_q;
  assign cmd_op_o    = cmd_op;
  assign cmd_data_o  = cmd_data;
  assign cmd_nack_o  = (state_q == S_RDATA) && last_byte;
  assign wtake_o     = (fire && state_q == S_WDATA) ? gnt_q : '0;
  assign done_o      = (state_q == S_DONE) ? gnt_q : '0;
  assign err_o       = (state_q == S_DONE) && err_q;
  assign gnt_o       = gnt_q;
  assign rdata_o     = rdata_q;
  assign rvalid_o    = rvalid_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      gnt_q    <= '0;
      dev_q    <= '0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      rem_q    <= '0;
      err_q    <= 1'b0;
      wait_q   <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= '0;

      if (state_q == S_IDLE && win_any) begin
        gnt_q   <= win;
        owner_q <= win_idx;
        dev_q   <= req_dev_i[int'(win_idx)*7 +: 7];
        rd_q    <= req_rd_i[win_idx];
        addr_q  <= req_addr_i[int'(win_idx)*8 +: 8];
        rem_q   <= {1'b0, req_len_i[int'(win_idx)*LEN_W +: LEN_W]} + REM_ONE;
        err_q   <= 1'b0;
        ptr_q   <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
      end

      if (state_q == S_DONE) gnt_q <= '0;

      if (cmd_done || timeout) wait_q <= 1'b0;
      else if (fire)           wait_q <= 1'b1;

      if (cmd_done && (state_q == S_WDATA || state_q == S_RDATA)) rem_q <= rem_q - REM_ONE;
      if ((cmd_done && rsp_nack_i && is_write_state(state_q)) || timeout) err_q <= 1'b1;

      if (cmd_done && state_q == S_RDATA) begin
        rdata_q  <= rsp_data_i;
        rvalid_q <= gnt_q;
      end
    end
  end

endmodule

// File: tb/tb_i2c_xfer_sched.sv
// Directed bench for i2c_xfer_sched with a model engine and a single EEPROM slave at 0x50.
module tb_i2c_xfer_sched;
  import i2c_sched_pkg::*;

  localparam int N  = 4;
  localparam int LW = 4;

  typedef logic [10:0] ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req = '0;
  logic [N*7-1:0]  req_dev = '0;
  logic [N-1:0]    req_rd = '0;
  logic [N*8-1:0]  req_addr = '0;
  logic [N*LW-1:0] req_len = '0;
  logic [N*8-1:0]  wdata;
  logic [N-1:0]    wtake_o, rvalid_o, gnt_o, done_o;
  logic [7:0]      rdata_o, cmd_data_o;
  logic [1:0]      cmd_op_o;
  logic            err_o, cmd_valid_o, cmd_nack_o, eng_abort_o;
  logic            cmd_ready = 1'b0, rsp_valid = 1'b0, rsp_nack = 1'b0;
  logic [7:0]      rsp_data = '0;

  i2c_xfer_sched #(.NUM_REQ(N), .LEN_W(LW), .TIMEOUT_CYCLES(100)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .req_dev_i(req_dev), .req_rd_i(req_rd),
    .req_addr_i(req_addr), .req_len_i(req_len), .wdata_i(wdata), .wtake_o(wtake_o),
    .rdata_o(rdata_o), .rvalid_o(rvalid_o), .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready), .cmd_op_o(cmd_op_o),
    .cmd_data_o(cmd_data_o), .cmd_nack_o(cmd_nack_o), .rsp_valid_i(rsp_valid),
    .rsp_data_i(rsp_data), .rsp_nack_i(rsp_nack), .eng_abort_o(eng_abort_o)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic ent_t enc(cmd_op_e op, logic [7:0] d, logic nk);
    return {op, nk, d};
  endfunction
  function automatic ent_t c_st();            return enc(OP_START, 8'h00, 1'b0); endfunction
  function automatic ent_t c_sp();            return enc(OP_STOP, 8'h00, 1'b0);  endfunction
  function automatic ent_t c_wr(logic [7:0] d); return enc(OP_WRITE, d, 1'b0);   endfunction
  function automatic ent_t c_rd(logic nk);      return enc(OP_READ, 8'h00, nk);  endfunction

  // Requester write-data sources: advance after the take edge.
  logic [7:0] wmem [N][16];
  int         widx [N];
  logic [N-1:0] take_seen = '0;
  int         wt_cnt [N];
  logic [11:0] rv_log [$];

  always_comb
    for (int r = 0; r < N; r++) wdata[r*8 +: 8] = wmem[r][widx[r] % 16];

  always @(negedge clk) begin
    take_seen = wtake_o;
    for (int r = 0; r < N; r++) if (wtake_o[r]) wt_cnt[r]++;
    if (rvalid_o != '0) rv_log.push_back({rvalid_o, rdata_o});
  end

  // Engine + slave model, driven just after each rising edge.
  int        eng_st = 0, lat_cnt = 0, cmd_cnt = 0;
  logic      mute = 1'b0;
  ent_t      cmd_log [$];
  cmd_op_e   pend_op = OP_START;
  logic [7:0] pend_data = '0;
  logic      sl_addr_phase = 1'b0, sl_sel = 1'b0, sl_first = 1'b0;
  logic [7:0] sl_ptr = '0;
  logic [7:0] mem [256];

  task automatic respond();
    rsp_valid = 1'b1;
    rsp_nack  = 1'b0;
    rsp_data  = 8'hEE;
    case (pend_op)
      OP_START: sl_addr_phase = 1'b1;
      OP_WRITE:
        if (sl_addr_phase) begin
          sl_addr_phase = 1'b0;
          sl_sel   = (pend_data[7:1] == 7'h50);
          sl_first = 1'b1;
          rsp_nack = !sl_sel;
        end else if (!sl_sel) rsp_nack = 1'b1;
        else if (sl_first) begin sl_ptr = pend_data; sl_first = 1'b0; end
        else begin mem[sl_ptr] = pend_data; sl_ptr++; end
      OP_READ: begin rsp_data = mem[sl_ptr]; sl_ptr++; end
      default: sl_sel = 1'b0;
    endcase
  endtask

  always begin
    @(posedge clk);
    #1;
    for (int r = 0; r < N; r++) if (take_seen[r]) widx[r]++;
    take_seen = '0;
    if (rst) begin
      eng_st = 0; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0;
    end else begin
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
      case (eng_st)
        0: if (cmd_valid_o && !mute) begin
             pend_op   = cmd_op_e'(cmd_op_o);
             pend_data = cmd_data_o;
             cmd_log.push_back(enc(pend_op, pend_op == OP_WRITE ? cmd_data_o : 8'h00,
                                   pend_op == OP_READ ? cmd_nack_o : 1'b0));
             cmd_ready = 1'b1;
             lat_cnt   = cmd_cnt % 3;
             if (cmd_cnt % 4 == 3) begin respond(); eng_st = 3; end
             else eng_st = 1;
             cmd_cnt++;
           end
        1: begin
             cmd_ready = 1'b0;
             check("valid_after_accept", 64'(cmd_valid_o), 64'(0));
             if (lat_cnt == 0) begin respond(); eng_st = 0; end
             else eng_st = 2;
           end
        2: begin
             lat_cnt--;
             if (lat_cnt == 0) begin respond(); eng_st = 0; end
           end
        default: begin cmd_ready = 1'b0; eng_st = 0; end
      endcase
    end
  end

  task automatic post(input int r, input logic [6:0] dev, input logic rd,
                      input logic [7:0] addr, input logic [LW-1:0] len);
    req_dev[r*7 +: 7]   = dev;
    req_rd[r]           = rd;
    req_addr[r*8 +: 8]  = addr;
    req_len[r*LW +: LW] = len;
    req[r]              = 1'b1;
  endtask

  task automatic wait_done(input int r, output logic e);
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (done_o != '0) break;
    end
    check($sformatf("done_sel_%0d", r), 64'(done_o), 64'(1) << r);
    check($sformatf("gnt_at_done_%0d", r), 64'(gnt_o), 64'(1) << r);
    e = err_o;
    req[r] = 1'b0;
  endtask

  task automatic check_log(input string tag, input ent_t exp [$]);
    check({tag, "_len"}, 64'(cmd_log.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < cmd_log.size(); i++)
      check($sformatf("%s_%0d", tag, i), 64'(cmd_log[i]), 64'(exp[i]));
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({gnt_o, done_o, err_o, cmd_valid_o, cmd_op_o, cmd_data_o, cmd_nack_o,
                wtake_o, rvalid_o, rdata_o, eng_abort_o});
  endfunction

  initial begin : main
    logic e;
    for (int r = 0; r < N; r++) begin widx[r] = 0; wt_cnt[r] = 0; end
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;

    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), 64'(0));
    rst = 1'b0;

    // Write of two bytes from requester 0
    wmem[0][0] = 8'hA5; wmem[0][1] = 8'h3C;
    post(0, 7'h50, 1'b0, 8'h10, 4'd1);
    @(negedge clk);
    check("gnt_registered", 64'(gnt_o), 64'(4'b0001));
    wait_done(0, e);
    check("wr_err", 64'(e), 64'(0));
    check("wr_takes", 64'(wt_cnt[0]), 64'(2));
    check_log("wr_cmds", '{c_st(), c_wr(8'hA0), c_wr(8'h10), c_wr(8'hA5), c_wr(8'h3C), c_sp()});
    @(negedge clk);
    check("gnt_cleared", 64'(gnt_o), 64'(0));

    // Read back the same two bytes from requester 1
    cmd_log.delete(); rv_log.delete();
    post(1, 7'h50, 1'b1, 8'h10, 4'd1);
    wait_done(1, e);
    check("rd_err", 64'(e), 64'(0));
    check_log("rd_cmds", '{c_st(), c_wr(8'hA0), c_wr(8'h10), c_st(), c_wr(8'hA1),
                           c_rd(1'b0), c_rd(1'b1), c_sp()});
    check("rd_count", 64'(rv_log.size()), 64'(2));
    if (rv_log.size() == 2) begin
      check("rd_byte0", 64'(rv_log[0]), 64'({4'b0010, 8'hA5}));
      check("rd_byte1", 64'(rv_log[1]), 64'({4'b0010, 8'h3C}));
    end

    // Absent device: NACK on the address byte
    cmd_log.delete(); wt_cnt[3] = 0;
    post(3, 7'h51, 1'b0, 8'h40, 4'd2);
    wait_done(3, e);
    check("nack_err", 64'(e), 64'(1));
    check_log("nack_cmds", '{c_st(), c_wr(8'hA2), c_sp()});
    check("nack_takes", 64'(wt_cnt[3]), 64'(0));
    @(negedge clk);

    // All four at once, pointer back at 0
    cmd_log.delete(); rv_log.delete();
    for (int r = 0; r < N; r++) begin widx[r] = 0; wmem[r][0] = 8'(8'h60 + r); end
    post(0, 7'h50, 1'b0, 8'h20, 4'd0);
    post(1, 7'h50, 1'b1, 8'h10, 4'd0);
    post(2, 7'h50, 1'b0, 8'h22, 4'd0);
    post(3, 7'h50, 1'b0, 8'h23, 4'd0);
    for (int k = 0; k < N; k++) begin
      wait_done(k, e);
      check($sformatf("rr_err_%0d", k), 64'(e), 64'(0));
      @(negedge clk);
      check($sformatf("rr_gap_%0d", k), 64'(gnt_o), 64'(0));
    end
    check_log("rr_cmds", '{c_st(), c_wr(8'hA0), c_wr(8'h20), c_wr(8'h60), c_sp(),
                           c_st(), c_wr(8'hA0), c_wr(8'h10), c_st(), c_wr(8'hA1), c_rd(1'b1), c_sp(),
                           c_st(), c_wr(8'hA0), c_wr(8'h22), c_wr(8'h62), c_sp(),
                           c_st(), c_wr(8'hA0), c_wr(8'h23), c_wr(8'h63), c_sp()});
    check("rr_rd_count", 64'(rv_log.size()), 64'(1));
    if (rv_log.size() == 1) check("rr_rd_byte", 64'(rv_log[0]), 64'({4'b0010, 8'hA5}));

    // Reset in the middle of the data phase, then a fresh transfer
    widx[0] = 0;
    wmem[0][0] = 8'h11; wmem[0][1] = 8'h22; wmem[0][2] = 8'h33; wmem[0][3] = 8'h44;
    post(0, 7'h50, 1'b0, 8'h30, 4'd3);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (wtake_o[0]) break;
    end
    check("mid_take_seen", 64'(wtake_o[0]), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    check("midreset_outputs", out_vec(), 64'(0));
    widx[0] = 0; wt_cnt[0] = 0;
    wmem[0][0] = 8'h77; wmem[0][1] = 8'h88;
    post(0, 7'h50, 1'b0, 8'h30, 4'd1);
    cmd_log.delete();
    rst = 1'b0;
    wait_done(0, e);
    check("post_reset_err", 64'(e), 64'(0));
    check("post_reset_takes", 64'(wt_cnt[0]), 64'(2));
    check_log("post_reset_cmds", '{c_st(), c_wr(8'hA0), c_wr(8'h30), c_wr(8'h77), c_wr(8'h88), c_sp()});
    @(negedge clk);

`ifdef I2C_XFER_SCHED_TIMEOUT_EN
    begin : timeout_test
      int c;
      cmd_log.delete();
      mute = 1'b1;
      post(2, 7'h50, 1'b0, 8'h00, 4'd0);
      for (int w = 0; w < 20 && !cmd_valid_o; w++) @(negedge clk);
      c = 1;
      while (!eng_abort_o && c < 300) begin
        @(negedge clk);
        c++;
      end
      check("abort_cycle", 64'(c), 64'(100));
      wait_done(2, e);
      check("abort_err", 64'(e), 64'(1));
      check("abort_no_cmds", 64'(cmd_log.size()), 64'(0));
      mute = 1'b0;
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
